// File: rtl/matmul_feeder_pkg.sv
// feeder_pkg: shared types and sizing helpers for the matmul_feeder slice.
//   feeder_state_t : FSM states (CLEAR is only reachable with FEEDER_CLEAR_EN)
//   operand_t      : default-width signed operand
//   accum_t        : default-width signed accumulator
//   STREAM_LEN(d)  : streaming cycles per pass (3*d-2)
//   CNT_W(d)       : width of the phase counter t
package feeder_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int BITS_C_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  typedef logic signed [BITS_AB_DEF-1:0] operand_t;
  typedef logic signed [BITS_C_DEF-1:0]  accum_t;

  function automatic int STREAM_LEN(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic int CNT_W(input int dim);
    return $clog2(3 * dim - 2);
  endfunction

endpackage

// File: rtl/matmul_feeder_operand_bank.sv
// operand_bank: DIM x DIM signed register file with one whole-row write port
// and a diagonally skewed read port.
//   clk, rst        : clock, asynchronous active-high reset (clears contents)
//   wr_en/wr_row    : overwrite row wr_row with wr_data (element c -> column c)
//   rd_en/rd_t      : skewed read at phase t; rd_data is 0 when rd_en is low
//   TRANSPOSE = 0   : rd_data[i] = M[i][t-i]  (A-side edge)
//   TRANSPOSE = 1   : rd_data[j] = M[t-j][j]  (B-side edge)
//   Lanes whose index t-i falls outside 0..DIM-1 read as 0.
module operand_bank
  import feeder_pkg::*;
#(
  parameter int DIM       = 8,
  parameter int BITS_AB   = 8,
  parameter int TRANSPOSE = 0,
  parameter int CW        = CNT_W(DIM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(DIM)-1:0]           wr_row,
  input  logic signed [DIM*BITS_AB-1:0]    wr_data,
  input  logic                             rd_en,
  input  logic [CW-1:0]                    rd_t,
  output logic signed [DIM*BITS_AB-1:0]    rd_data
);

  localparam int RW = $clog2(DIM);

  logic signed [BITS_AB-1:0] mem_q [DIM][DIM];
  logic signed [BITS_AB-1:0] mem_d [DIM][DIM];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int c = 0; c < DIM; c++) begin
        mem_d[wr_row][c] = wr_data[c*BITS_AB +: BITS_AB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Lane i sees the element whose diagonal index t-i lands inside the tile.
  always_comb begin
    int          k;
    logic [RW-1:0] k_idx;
    logic [RW-1:0] i_idx;
    rd_data = '0;
    k       = 0;
    k_idx   = '0;
    i_idx   = '0;
    for (int i = 0; i < DIM; i++) begin
      k     = int'(rd_t) - i;
      k_idx = RW'(k);
      i_idx = RW'(i);
      if (rd_en && (k >= 0) && (k < DIM)) begin
        if (TRANSPOSE == 0) begin
          rd_data[i*BITS_AB +: BITS_AB] = mem_q[i_idx][k_idx];
        end else begin
          rd_data[i*BITS_AB +: BITS_AB] = mem_q[k_idx][i_idx];
        end
      end
    end
  end

endmodule

// File: rtl/matmul_feeder.sv
// matmul_feeder: operand staging and skew stage in front of a DIM x DIM
// systolic array. Host writes A/B tiles row by row while idle; start streams
// both tiles diagonally skewed, holds arr_en for 3*DIM-2 cycles, then pulses
// done for one cycle.
//   clk, rst             : clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_row  : row write (wr_sel 0 = A bank, 1 = B bank)
//   wr_data, wr_ready    : row data; writes only land while wr_ready (IDLE)
//   start, busy, done    : pass control / status
//   arr_A, arr_B, arr_en : skewed operand edges and MAC enable
//   arr_WrEn, arr_Crow, arr_Cin : accumulator clear port (arr_Cin is always 0)
// Build option: define FEEDER_CLEAR_EN to insert a DIM-cycle CLEAR phase
// (arr_WrEn=1, arr_Crow walks 0..DIM-1) before each STREAM phase.
module matmul_feeder
  import feeder_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [$clog2(DIM)-1:0]        wr_row,
  input  logic signed [DIM*BITS_AB-1:0] wr_data,
  output logic                          wr_ready,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic signed [DIM*BITS_AB-1:0] arr_A,
  output logic signed [DIM*BITS_AB-1:0] arr_B,
  output logic                          arr_en,
  output logic                          arr_WrEn,
  output logic [$clog2(DIM)-1:0]        arr_Crow,
  output logic signed [DIM*BITS_C-1:0]  arr_Cin
);

  localparam int RW  = $clog2(DIM);
  localparam int LEN = STREAM_LEN(DIM);
  localparam int CW  = CNT_W(DIM);
  localparam logic [CW-1:0] T_LAST = CW'(LEN - 1);
`ifdef FEEDER_CLEAR_EN
  localparam logic [CW-1:0] T_CLR_LAST = CW'(DIM - 1);
`endif

  feeder_state_t state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic          done_q, done_d;
  logic          wr_go;
  logic          streaming;

  assign wr_go     = wr_en && (state_q == IDLE);
  assign streaming = (state_q == STREAM);

  operand_bank #(
    .DIM(DIM), .BITS_AB(BITS_AB), .TRANSPOSE(0), .CW(CW)
  ) u_bank_a (
    .clk(clk), .rst(rst),
    .wr_en(wr_go && !wr_sel), .wr_row(wr_row), .wr_data(wr_data),
    .rd_en(streaming), .rd_t(t_q), .rd_data(arr_A)
  );

  operand_bank #(
    .DIM(DIM), .BITS_AB(BITS_AB), .TRANSPOSE(1), .CW(CW)
  ) u_bank_b (
    .clk(clk), .rst(rst),
    .wr_en(wr_go && wr_sel), .wr_row(wr_row), .wr_data(wr_data),
    .rd_en(streaming), .rd_t(t_q), .rd_data(arr_B)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef FEEDER_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = STREAM;
`endif
          t_d = '0;
        end
      end
`ifdef FEEDER_CLEAR_EN
      CLEAR: begin
        if (t_q == T_CLR_LAST) begin
          state_d = STREAM;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
`endif
      STREAM: begin
        // Last cycle drains the array; done is registered so it lands in IDLE.
        if (t_q == T_LAST) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign arr_en   = streaming;
  assign arr_Cin  = '0;

`ifdef FEEDER_CLEAR_EN
  assign arr_WrEn = (state_q == CLEAR);
  assign arr_Crow = (state_q == CLEAR) ? t_q[RW-1:0] : '0;
`else
  assign arr_WrEn = 1'b0;
  assign arr_Crow = '0;
`endif

endmodule

// File: tb/tb_matmul_feeder.sv
// Bench for matmul_feeder at DIM=4: skew table, identity/counting pass,
// busy protocol with chained start, same-cycle write+start, async reset.
module tb_matmul_feeder;
  import feeder_pkg::*;

  localparam int DIM = 4;
  localparam int BA  = 8;
  localparam int BC  = 16;
  localparam int W   = DIM * BA;
  localparam int RW  = $clog2(DIM);
  localparam int LEN = 3 * DIM - 2;
`ifdef FEEDER_CLEAR_EN
  localparam int CLR = DIM;
`else
  localparam int CLR = 0;
`endif

  logic                 clk, rst, wr_en, wr_sel, wr_ready, start, busy, done;
  logic [RW-1:0]        wr_row;
  logic signed [W-1:0]  wr_data, arr_A, arr_B;
  logic                 arr_en, arr_WrEn;
  logic [RW-1:0]        arr_Crow;
  logic signed [DIM*BC-1:0] arr_Cin;

  matmul_feeder #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .busy(busy),
    .done(done), .arr_A(arr_A), .arr_B(arr_B), .arr_en(arr_en),
    .arr_WrEn(arr_WrEn), .arr_Crow(arr_Crow), .arr_Cin(arr_Cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  operand_t ma [DIM][DIM];
  operand_t mb [DIM][DIM];

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    int           t;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         en;
    logic         dn;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (time %0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_a(input int t);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++)
      if (t - i >= 0 && t - i < DIM) r[i*BA +: BA] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_b(input int t);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < DIM; j++)
      if (t - j >= 0 && t - j < DIM) r[j*BA +: BA] = mb[t-j][j];
    return r;
  endfunction

  task automatic write_row(input logic sel, input int row, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = RW'(row);
    wr_data = data;
    for (int c = 0; c < DIM; c++) begin
      if (sel) mb[row][c] = data[c*BA +: BA];
      else     ma[row][c] = data[c*BA +: BA];
    end
    tick();
    wr_en = 1'b0;
  endtask

  // Raise start (optionally with a same-cycle A row 0 write) and queue the
  // skewed operands the pass should produce from the model banks.
  task automatic issue_start(input logic wr_a0, input logic [BA-1:0] val);
    start = 1'b1;
    if (wr_a0) begin
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_row  = '0;
      wr_data = {DIM{val}};
      for (int c = 0; c < DIM; c++) ma[0][c] = val;
    end
    for (int t = 0; t < LEN; t++) sb.push_back({exp_a(t), exp_b(t)});
  endtask

  // Follows one pass from the cycle after start through the done cycle.
  task automatic watch_pass(input int poke_t, input logic chain);
    exp_t e;
    logic en_x;
    for (int cyc = 0; cyc <= CLR + LEN; cyc++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      en_x  = (cyc >= CLR) && (cyc < CLR + LEN);
      chk("ctl busy/en/done/wren", {busy, arr_en, done, arr_WrEn},
          {(cyc < CLR + LEN), en_x, (cyc == CLR + LEN), (cyc < CLR)});
      chk("arr_Crow", arr_Crow, (cyc < CLR) ? cyc : 0);
      if (en_x) begin
        if (sb.size() == 0) begin
          chk("scoreboard empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("arr_A", arr_A, e.a);
          chk("arr_B", arr_B, e.b);
        end
      end
      if (cyc == CLR + poke_t) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = RW'(3);
        wr_data = {DIM{8'h5A}};
      end
      if (chain && cyc == CLR + LEN) issue_start(1'b0, '0);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    int cur;
    rst = 1'b1; wr_en = 0; wr_sel = 0; wr_row = '0; wr_data = '0; start = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin ma[r][c] = '0; mb[r][c] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctl", {wr_ready, busy, done, arr_en, arr_WrEn}, 5'b10000);
    chk("reset data", {arr_A, arr_B}, 64'd0);
    chk("reset crow/cin", {arr_Crow, arr_Cin}, 0);
    rst = 1'b0;
    tick();

    // Skew table: A[i][k]=10i+k, B all ones
    tv[0]  = '{0,  32'h00000000, 32'h00000001, 1'b1, 1'b0};
    tv[1]  = '{1,  32'h00000A01, 32'h00000101, 1'b1, 1'b0};
    tv[2]  = '{2,  32'h00140B02, 32'h00010101, 1'b1, 1'b0};
    tv[3]  = '{3,  32'h1E150C03, 32'h01010101, 1'b1, 1'b0};
    tv[4]  = '{4,  32'h1F160D00, 32'h01010100, 1'b1, 1'b0};
    tv[5]  = '{5,  32'h20170000, 32'h01010000, 1'b1, 1'b0};
    tv[6]  = '{6,  32'h21000000, 32'h01000000, 1'b1, 1'b0};
    tv[7]  = '{7,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tv[8]  = '{8,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tv[9]  = '{9,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tv[10] = '{10, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) d[c*BA +: BA] = BA'(10 * r + c);
      write_row(1'b0, r, d);
      write_row(1'b1, r, {DIM{8'd1}});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CLR) tick();
    cur = 0;
    for (int k = 0; k < 11; k++) begin
      while (cur < tv[k].t) begin tick(); cur++; end
      chk($sformatf("skew A t=%0d", tv[k].t), arr_A, tv[k].a);
      chk($sformatf("skew B t=%0d", tv[k].t), arr_B, tv[k].b);
      chk($sformatf("skew en/done t=%0d", tv[k].t), {arr_en, done}, {tv[k].en, tv[k].dn});
    end
    tick();

    // Identity x counting
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) d[c*BA +: BA] = (r == c) ? 8'd1 : 8'd0;
      write_row(1'b0, r, d);
      for (int c = 0; c < DIM; c++) d[c*BA +: BA] = BA'(r * DIM + c);
      write_row(1'b1, r, d);
    end
    issue_start(1'b0, '0);
    watch_pass(999, 1'b0);
    tick();
    chk("idle after identity", {busy, done, wr_ready}, 3'b001);

    // Busy protocol: start + write at t=5 ignored, start in done cycle accepted
    issue_start(1'b0, '0);
    watch_pass(5, 1'b1);
    watch_pass(999, 1'b0);
    tick();
    chk("idle after chained pass", {busy, done, wr_ready}, 3'b001);

    // Same-cycle write + start
    issue_start(1'b1, 8'd7);
    watch_pass(999, 1'b0);
    tick();
    chk("idle after same-cycle pass", {busy, done}, 2'b00);

    // Asynchronous reset mid-STREAM
    issue_start(1'b0, '0);
    tick();
    start = 1'b0;
    repeat (CLR + 5) tick();
    chk("pre-reset streaming", {busy, arr_en}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async reset ctl", {wr_ready, busy, done, arr_en, arr_WrEn}, 5'b10000);
    chk("async reset data", {arr_A, arr_B}, 64'd0);
    chk("async reset crow", arr_Crow, 0);
    sb.delete();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    tick();
    rst = 1'b0;
    for (int k = 0; k < LEN + CLR; k++) begin
      tick();
      chk("no done after reset", {busy, done}, 2'b00);
    end
    issue_start(1'b0, '0);
    watch_pass(999, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_feeder.md
# matmul_feeder

Operand staging and skew stage directly upstream of the systolic array. Holds one DIM×DIM A tile and one DIM×DIM B tile written row-by-row from the host side. On start, it streams both tiles into the array's A/B edge inputs in diagonal-skewed order and drives the array's `en` for exactly as many cycles as the last MAC needs. It then pulses `done`. The `Crow`/`WrEn`/`Cin` port exists for an optional accumulator-clear phase.

## Interface
- `BITS_AB`, 8: signed operand width.
- `BITS_C`, 16: accumulator width; sizes `arr_Cin` only.
- `DIM`, 8: array dimension; must be ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  write one operand row this cycle.
- `wr_sel`  in  1  0 = A bank, 1 = B bank.
- `wr_row`  in  $clog2(DIM)  row index.
- `wr_data`  in  DIM×BITS_AB signed  row contents; element c goes to column c.
- `wr_ready`  out  1  high only in IDLE; writes with `wr_ready` low are dropped.
- `start`  in  1  begin a tile pass; sampled only in IDLE.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the final streaming cycle.
- `arr_A`  out  DIM×BITS_AB signed  to array A inputs.
- `arr_B`  out  DIM×BITS_AB signed  to array B inputs.
- `arr_en`  out  1  array MAC enable.
- `arr_WrEn`  out  1  array C write enable.
- `arr_Crow`  out  $clog2(DIM)  array row select.
- `arr_Cin`  out  DIM×BITS_C signed  array C write data; always 0.

## Operation
- The two banks, A[r][c] and B[r][c], are register arrays reset to 0.
- A write occurs when `wr_en && wr_ready`. It takes effect at the clock edge and overwrites the whole row.
- FSM states are IDLE, CLEAR (only when `FEEDER_CLEAR_EN` is defined), STREAM.
- IDLE→CLEAR (or →STREAM) when `start` is high. In the same edge, counter t is set to 0.
- CLEAR runs DIM cycles with t = 0..DIM-1. It drives `arr_WrEn`=1 and `arr_Crow`=t. It then enters STREAM with t=0.
- STREAM runs 3·DIM−2 cycles with t = 0..3·DIM−3. `arr_en`=1 throughout. It returns to IDLE after t=3·DIM−3.
- Skew in STREAM:
  - `arr_A[i]` = A[i][t−i] when 0 ≤ t−i < DIM, else 0.
  - `arr_B[j]` = B[t−j][j] when 0 ≤ t−j < DIM, else 0.
- All inputs are 0 for t ≥ 2·DIM−1. The remaining cycles drain the array pipeline.
- Outside the active state: `arr_en`=0, `arr_WrEn`=0, `arr_Crow`=0, `arr_A`/`arr_B`=0.
- `start` while busy is ignored, with no queuing.
- `start` and a write in the same IDLE cycle: the write lands first, and the pass uses the updated contents.
- `done` is registered. It is high during the first IDLE cycle after STREAM, which is also the cycle `wr_ready` returns high. A new `start` in that cycle is accepted.
- Reset mid-pass: FSM goes to IDLE, t=0, banks go to 0, and every output goes to 0 immediately (asynchronous). No `done` is produced.

## Timing
- Reset values: `wr_ready`=1; `busy`, `done`, `arr_en`, `arr_WrEn` = 0; `arr_Crow`, `arr_A`, `arr_B`, `arr_Cin` = 0.
- Outputs decode only from registered state, t and the banks. There are no combinational paths from inputs to outputs.
- Cycle of the `start` edge = S. `busy` and t=0 outputs are valid from S+1.
- Without CLEAR:
  - `arr_en` is high S+1..S+3·DIM−2.
  - `done` is at S+3·DIM−1.
  - Start-to-start minimum is 3·DIM−1 cycles.
- With CLEAR, add DIM cycles to all of the above.
- Writes complete in one cycle. Every row is written in DIM cycles per bank.

## Configuration
- `FEEDER_CLEAR_EN` defined: CLEAR phase present; each pass zeroes all DIM accumulator rows before streaming.
- `FEEDER_CLEAR_EN` undefined: no CLEAR state; `arr_WrEn` is tied 0, and accumulators sum across passes.
- In both cases `arr_Cin` is tied 0.

## Structure
- `feeder_pkg`:
  - state enum `feeder_state_t`
  - `localparam`-style functions `STREAM_LEN(DIM)=3*DIM-2` and `CNT_W(DIM)=$clog2(3*DIM-2)`
  - `operand_t`/`accum_t` signed typedefs
- Sub-module `operand_bank`: DIM×DIM register file with one row write port and a skewed read port.
  - Parameter `TRANSPOSE`: 0 gives A-style indexing, 1 gives B-style.
  - Instantiated twice. The FSM and counter stay in `matmul_feeder`.

## Test plan
- **Reset defaults.** Pulse `rst` mid-STREAM of a loaded pass → all outputs 0 asynchronously, then `wr_ready`=1, banks read back 0, no `done`.
- **Identity × counting.** DIM=8, A=I, B[r][c]=r·8+c. Start → `arr_en` high for 22 cycles, `done` at S+23. Captured array rows equal B.
- **Skew check.** DIM=4, A[i][k]=10·i+k, B all 1. At t=3 → `arr_A`={3,12,21,30}. At t=6 → `arr_A`={0,0,0,33}. At t=7..9 → `arr_A`=0.
- **Busy protocol.** Pulse `start` and `wr_en` at t=5 → both ignored, and bank contents are unchanged. `start` in the `done` cycle → new pass begins next cycle.
- **Same-cycle write+start.** Write A row 0 = {7,…} together with `start` → `arr_A[0]`=7 at t=0.
- **`FEEDER_CLEAR_EN`.** Run two back-to-back passes of the same tile → with the macro, results are identical and `arr_Crow` walks 0..7 with `arr_WrEn`=1 for 8 cycles. Without the macro, pass 2 results are 2× pass 1.
